ravan_block_packer: RTL

- Upstream feeder for the RAVAN 64-bit encryption core.
- Accepts a byte stream with valid/ready and s_last message framing.
- Packs the bytes MSB-first into 64-bit blocks and applies PKCS#7-style padding at the end of each message.
- Presents each finished block on a registered valid/ready output that drives the core's data_in.

---
 rtl/ravan_block_packer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ravan_block_packer.sv
// Byte-stream to 64-bit block packer feeding the RAVAN encryption core.
// Packs bytes MSB-first and pads the tail of each message.
module ravan_block_packer #(
    parameter bit PAD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [63:0]      m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic {FILL, PAD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [63:0]      asm_q, asm_d;
    logic             m_valid_q;
    logic [63:0]      m_data_q;
    logic             m_last_q;
    logic [CNT_W-1:0] blk_q;

    logic        free, s_acc, m_hs;
    logic [5:0]  sh;
    logic [7:0]  padv;
    logic [63:0] merged, padded;
    logic        load, ld_last;
    logic [63:0] ld_data;

    assign free    = !m_valid_q || m_ready;
    assign s_ready = !rst && (state_q == FILL) && ((idx_q != 3'd7) || free);
    assign s_acc   = s_valid && s_ready;
    assign m_hs    = m_valid_q && m_ready;
    assign sh      = 6'd63 - {idx_q, 3'b000};
    assign padv    = PAD_EN ? {5'b0, 3'd7 - idx_q} : 8'h00;

    always_comb begin
        merged = asm_q;
        merged[sh -: 8] = s_data;
        // Bytes past the one just accepted become padding.
        padded = merged;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) > idx_q) begin
                padded[63-8*j -: 8] = padv;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        load    = 1'b0;
        ld_data = merged;
        ld_last = 1'b0;
        unique case (state_q)
            FILL: begin
                if (s_acc) begin
                    asm_d = merged;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        load  = 1'b1;
                        idx_d = 3'd0;
                        asm_d = '0;
                        if (s_last && PAD_EN) begin
                            asm_d   = {8{8'h08}};
                            state_d = PAD;
                        end else begin
                            ld_last = s_last;
                        end
                    end else if (s_last) begin
                        asm_d   = padded;
                        idx_d   = 3'd0;
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                if (free) begin
                    load    = 1'b1;
                    ld_data = asm_q;
                    ld_last = 1'b1;
                    asm_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            idx_q     <= 3'd0;
            asm_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            blk_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= ld_data;
                m_last_q  <= ld_last;
            end else if (m_hs) begin
                m_valid_q <= 1'b0;
            end
            if (m_hs) begin
                blk_q <= m_last_q ? '0 : blk_q + CNT_W'(1);
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign blk_count = blk_q;

endmodule
